// File: rtl/wb_select_stage_pkg.sv
// rtl/wb_select_stage_pkg.sv - shared source indices and state encoding for the write-back select stage
//
// Purpose: constants and types shared by wb_select_stage and its encoder.
//   SRC_*       : canonical result-source slot indices on src_data/src_req.
//   wb_state_t  : control state of the stage (idle / waiting for data memory).
package wb_select_stage_pkg;

  localparam int SRC_PC   = 0;
  localparam int SRC_CALL = 1;
  localparam int SRC_ALU  = 2;
  localparam int SRC_LOAD = 3;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_prio_encoder.sv
// rtl/wb_prio_encoder.sv - lowest-index-wins priority encoder for source requests
//
// Purpose: turn an NSRC-bit request vector into the index of the lowest set bit.
// Ports:
//   i_req : NSRC-bit request vector, bit 0 highest priority
//   o_idx : SELW-bit index of the lowest set bit (0 when none set)
//   o_any : 1 when at least one request bit is set
module wb_prio_encoder #(
  parameter int NSRC = 4,
  parameter int SELW = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] i_req,
  output logic [SELW-1:0] o_idx,
  output logic            o_any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = SELW'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_select_stage.sv
// rtl/wb_select_stage.sv - MEM-to-WB result select with multi-cycle load completion
//
// Purpose: pick the write-back result among NSRC sources by fixed priority and
// register it, stalling upstream while a selected load waits for data memory.
// Ports:
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   in_valid       : MEM-stage instruction present
//   src_req        : per-source request, bit 0 highest priority
//   src_data       : packed sources, slot i at [i*WIDTH +: WIDTH]
//   rd_in, we_in   : destination register and write enable of the instruction
//   mem_rdy        : data-memory output valid on slot LOAD_IDX
//   stall          : combinational hold request to MEM stage and upstream
//   wb_valid, wb_data, wb_rd, wb_we, wb_sel : registered write-back slot
module wb_select_stage
  import wb_select_stage_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NSRC        = 4,
  parameter int LOAD_IDX    = SRC_LOAD,
  parameter int DEFAULT_IDX = SRC_PC,
  parameter int SELW        = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [NSRC-1:0]       src_req,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [4:0]            rd_in,
  input  logic                  we_in,
  input  logic                  mem_rdy,
  output logic                  stall,
  output logic                  wb_valid,
  output logic [WIDTH-1:0]      wb_data,
  output logic [4:0]            wb_rd,
  output logic                  wb_we,
  output logic [SELW-1:0]       wb_sel
);

  localparam logic [SELW-1:0] L_LOAD_SEL    = SELW'(LOAD_IDX);
  localparam logic [SELW-1:0] L_DEFAULT_SEL = SELW'(DEFAULT_IDX);

  wb_state_t        r_state;
  logic [4:0]       r_pend_rd;
  logic             r_pend_we;
  logic             r_wb_valid;
  logic [WIDTH-1:0] r_wb_data;
  logic [4:0]       r_wb_rd;
  logic             r_wb_we;
  logic [SELW-1:0]  r_wb_sel;

  logic [SELW-1:0]  w_enc_idx;
  logic             w_enc_any;
  logic [SELW-1:0]  w_sel;
  logic [WIDTH-1:0] w_slots [NSRC];
  logic             w_load_wait_entry;

  wb_prio_encoder #(
    .NSRC (NSRC),
    .SELW (SELW)
  ) u_prio (
    .i_req (src_req),
    .o_idx (w_enc_idx),
    .o_any (w_enc_any)
  );

  // No request means the instruction writes back the PC path.
  assign w_sel = w_enc_any ? w_enc_idx : L_DEFAULT_SEL;

  for (genvar g = 0; g < NSRC; g++) begin : g_slot
    assign w_slots[g] = src_data[g*WIDTH +: WIDTH];
  end

  assign w_load_wait_entry = in_valid && (w_sel == L_LOAD_SEL) && !mem_rdy;

  // Reset wins so a half-finished load never holds the pipeline.
  assign stall = !reset && !mem_rdy &&
                 (r_state == ST_LOAD_WAIT ||
                  (r_state == ST_IDLE && in_valid && w_sel == L_LOAD_SEL));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pend_rd  <= '0;
      r_pend_we  <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_rd    <= '0;
      r_wb_we    <= 1'b0;
      r_wb_sel   <= L_DEFAULT_SEL;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!in_valid) begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
          end else if (w_load_wait_entry) begin
            // Destination is parked separately so wb_rd keeps its last value
            // while the write-back slot is empty.
            r_state    <= ST_LOAD_WAIT;
            r_pend_rd  <= rd_in;
            r_pend_we  <= we_in;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
          end else begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= w_slots[w_sel];
            r_wb_rd    <= rd_in;
            r_wb_we    <= we_in;
            r_wb_sel   <= w_sel;
          end
        end
        ST_LOAD_WAIT: begin
          if (mem_rdy) begin
            r_state    <= ST_IDLE;
            r_wb_valid <= 1'b1;
            r_wb_data  <= w_slots[LOAD_IDX];
            r_wb_rd    <= r_pend_rd;
            r_wb_we    <= r_pend_we;
            r_wb_sel   <= L_LOAD_SEL;
          end else begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wb_valid <= 1'b0;
          r_wb_we    <= 1'b0;
        end
      endcase
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_data  = r_wb_data;
  assign wb_rd    = r_wb_rd;
  assign wb_we    = r_wb_we;
  assign wb_sel   = r_wb_sel;

endmodule

// File: tb/tb_wb_select_stage.sv
// tb/tb_wb_select_stage.sv - directed self-checking bench for wb_select_stage
module tb_wb_select_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [3:0]   src_req;
  logic [127:0] src_data;
  logic [4:0]   rd_in;
  logic         we_in;
  logic         mem_rdy;
  logic         stall;
  logic         wb_valid;
  logic [31:0]  wb_data;
  logic [4:0]   wb_rd;
  logic         wb_we;
  logic [1:0]   wb_sel;

  logic [7:0]   req8;
  logic [511:0] data8;
  logic         stall8, valid8, we8;
  logic [63:0]  wdata8;
  logic [4:0]   rd8;
  logic [2:0]   sel8;

  logic [1:0]   req2;
  logic [127:0] data2;
  logic         stall2, valid2, we2;
  logic [63:0]  wdata2;
  logic [4:0]   rd2;
  logic [0:0]   sel2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_select_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .src_req(src_req),
    .src_data(src_data), .rd_in(rd_in), .we_in(we_in), .mem_rdy(mem_rdy),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_we(wb_we), .wb_sel(wb_sel)
  );

  wb_select_stage #(.WIDTH(64), .NSRC(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .src_req(req8),
    .src_data(data8), .rd_in(rd_in), .we_in(we_in), .mem_rdy(mem_rdy),
    .stall(stall8), .wb_valid(valid8), .wb_data(wdata8), .wb_rd(rd8),
    .wb_we(we8), .wb_sel(sel8)
  );

  wb_select_stage #(.WIDTH(64), .NSRC(2), .LOAD_IDX(1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .src_req(req2),
    .src_data(data2), .rd_in(rd_in), .we_in(we_in), .mem_rdy(mem_rdy),
    .stall(stall2), .wb_valid(valid2), .wb_data(wdata2), .wb_rd(rd2),
    .wb_we(we2), .wb_sel(sel2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] slot_val(input int j);
    return {32'(j) + 32'h0000_0100, 32'hA5A5_0000 | 32'(j)};
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; src_req = '0; src_data = '0;
    rd_in = '0; we_in = 1'b0; mem_rdy = 1'b0;
    req8 = '0; data8 = '0; req2 = '0; data2 = '0;
    step();
    step();
    check("rst_valid", 64'(wb_valid), 64'd0);
    check("rst_we",    64'(wb_we),    64'd0);
    check("rst_data",  64'(wb_data),  64'd0);
    check("rst_rd",    64'(wb_rd),    64'd0);
    check("rst_sel",   64'(wb_sel),   64'd0);
    // Load pending with memory not ready: reset must still hold stall low.
    in_valid = 1'b1; src_req = 4'b1000;
    #1;
    check("rst_stall", 64'(stall), 64'd0);

    // Single ALU result
    reset = 1'b0;
    src_req = 4'b0100; src_data[64 +: 32] = 32'h0000_1234; rd_in = 5; we_in = 1'b1;
    #1;
    check("alu_stall", 64'(stall), 64'd0);
    step();
    check("alu_valid", 64'(wb_valid), 64'd1);
    check("alu_data",  64'(wb_data),  64'h1234);
    check("alu_rd",    64'(wb_rd),    64'd5);
    check("alu_we",    64'(wb_we),    64'd1);
    check("alu_sel",   64'(wb_sel),   64'd2);

    // Priority among several requests
    src_req = 4'b0110; src_data[32 +: 32] = 32'hAAAA_0001; rd_in = 7; we_in = 1'b0;
    step();
    check("prio_sel",  64'(wb_sel),  64'd1);
    check("prio_data", 64'(wb_data), 64'hAAAA_0001);
    check("prio_we",   64'(wb_we),   64'd0);

    // No request falls back to the PC slot
    src_req = 4'b0000; src_data[0 +: 32] = 32'h0000_0100; rd_in = 9; we_in = 1'b1;
    step();
    check("dflt_sel",  64'(wb_sel),  64'd0);
    check("dflt_data", 64'(wb_data), 64'h100);

    // Bubble: valid/we drop, the rest holds
    in_valid = 1'b0; rd_in = 22; src_req = 4'b0100;
    step();
    check("bub_valid", 64'(wb_valid), 64'd0);
    check("bub_we",    64'(wb_we),    64'd0);
    check("bub_data",  64'(wb_data),  64'h100);
    check("bub_rd",    64'(wb_rd),    64'd9);
    check("bub_sel",   64'(wb_sel),   64'd0);

    // Load waiting three cycles for data memory
    in_valid = 1'b1; src_req = 4'b1000; mem_rdy = 1'b0; rd_in = 12; we_in = 1'b1;
    src_data[96 +: 32] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("ld_stall%0d", k), 64'(stall), 64'd1);
      step();
      check($sformatf("ld_valid%0d", k), 64'(wb_valid), 64'd0);
      // Upstream fields change while waiting; the latched ones must be used.
      rd_in = 3; we_in = 1'b0; src_req = 4'b0100;
    end
    mem_rdy = 1'b1; src_data[96 +: 32] = 32'hDEAD_BEEF;
    #1;
    check("ld_rdy_stall", 64'(stall), 64'd0);
    step();
    check("ld_valid", 64'(wb_valid), 64'd1);
    check("ld_data",  64'(wb_data),  64'hDEAD_BEEF);
    check("ld_rd",    64'(wb_rd),    64'd12);
    check("ld_we",    64'(wb_we),    64'd1);
    check("ld_sel",   64'(wb_sel),   64'd3);

    // Ready load followed directly by an ALU op
    src_req = 4'b1000; src_data[96 +: 32] = 32'hCAFE_0003; rd_in = 4; we_in = 1'b1;
    #1;
    check("b2b_stall0", 64'(stall), 64'd0);
    step();
    check("b2b_valid0", 64'(wb_valid), 64'd1);
    check("b2b_sel0",   64'(wb_sel),   64'd3);
    check("b2b_data0",  64'(wb_data),  64'hCAFE_0003);
    src_req = 4'b0100; src_data[64 +: 32] = 32'h0000_0022; rd_in = 6;
    #1;
    check("b2b_stall1", 64'(stall), 64'd0);
    step();
    check("b2b_valid1", 64'(wb_valid), 64'd1);
    check("b2b_sel1",   64'(wb_sel),   64'd2);
    check("b2b_rd1",    64'(wb_rd),    64'd6);

    // Reset in the middle of a load wait abandons it
    src_req = 4'b1000; mem_rdy = 1'b0; rd_in = 10;
    step();
    step();
    #1;
    check("rlw_stall_pre", 64'(stall), 64'd1);
    reset = 1'b1;
    #1;
    check("rlw_stall_rst", 64'(stall), 64'd0);
    step();
    check("rlw_valid", 64'(wb_valid), 64'd0);
    check("rlw_stall", 64'(stall),    64'd0);
    check("rlw_sel",   64'(wb_sel),   64'd0);
    reset = 1'b0; in_valid = 1'b0; mem_rdy = 1'b1;
    step();
    check("rlw_nowb0", 64'(wb_valid), 64'd0);
    step();
    check("rlw_nowb1", 64'(wb_valid), 64'd0);

    // Parameter sweep on the 8-source and 2-source instances, WIDTH=64
    in_valid = 1'b1; mem_rdy = 1'b1; we_in = 1'b1; src_req = '0;
    for (int j = 0; j < 8; j++) data8[j*64 +: 64] = slot_val(j);
    for (int j = 0; j < 2; j++) data2[j*64 +: 64] = ~slot_val(j);
    for (int i = 0; i < 8; i++) begin
      req8 = 8'hFF << i;
      req2 = (i < 2) ? 2'(2'b11 << i) : 2'b00;
      rd_in = 5'(i + 16);
      step();
      check($sformatf("n8_sel%0d", i),  64'(sel8), 64'(i));
      check($sformatf("n8_data%0d", i), wdata8, slot_val(i));
      check($sformatf("n8_rd%0d", i),   64'(rd8), 64'(i + 16));
      if (i < 2) begin
        check($sformatf("n2_sel%0d", i),  64'(sel2), 64'(i));
        check($sformatf("n2_data%0d", i), wdata2, ~slot_val(i));
      end
    end
    req8 = '0; req2 = '0;
    step();
    check("n8_dflt_sel",  64'(sel8), 64'd0);
    check("n8_dflt_data", wdata8,    slot_val(0));
    check("n2_dflt_sel",  64'(sel2), 64'd0);
    check("n2_dflt_data", wdata2,    ~slot_val(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_select_stage.md
WB_SELECT_STAGE -- requirements
Module: wb_select_stage

Interface
REQ-001 Parameter WIDTH, default 32: data-path width of every source and of the write-back result.
REQ-002 Parameter NSRC, default 4: number of result sources; legal range 2..8.
REQ-003 Parameter LOAD_IDX, default 3: index of the source that is data-memory output and may need multi-cycle completion.
REQ-004 Parameter DEFAULT_IDX, default 0: source used when no request bit is set (PC path).
REQ-005 Parameter SELW, default $clog2(NSRC): width of the encoded select.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 in_valid  input  1  MEM-stage instruction present this cycle.
REQ-010 src_req  input  NSRC  per-source request (jmpl, call, load, ...); bit 0 is highest priority.
REQ-011 src_data  input  NSRC*WIDTH  packed source values; source i occupies bits [i*WIDTH +: WIDTH].
REQ-012 rd_in  input  5  destination register of the MEM-stage instruction.
REQ-013 we_in  input  1  MEM-stage register-file write enable.
REQ-014 mem_rdy  input  1  data-memory output valid on src_data slot LOAD_IDX.
REQ-015 stall  output  1  hold MEM stage and upstream; combinational.
REQ-016 wb_valid  output  1  registered write-back slot valid.
REQ-017 wb_data  output  WIDTH  registered selected result.
REQ-018 wb_rd  output  5  registered destination register.
REQ-019 wb_we  output  1  registered write enable; equals wb_valid AND captured we_in.
REQ-020 wb_sel  output  SELW  registered index of the source used.

Function
REQ-021 Selection: sel = lowest index i with src_req[i]=1; sel = DEFAULT_IDX when src_req is all zero.
REQ-022 States: IDLE and LOAD_WAIT; state register is the only control state.
REQ-023 IDLE, in_valid=1, sel!=LOAD_IDX: next edge captures src_data[sel], rd_in, we_in, sel; wb_valid=1; latency one cycle; stall=0.
REQ-024 IDLE, in_valid=1, sel=LOAD_IDX, mem_rdy=1: capture as REQ-023 in the same cycle; stall=0.
REQ-025 IDLE, in_valid=1, sel=LOAD_IDX, mem_rdy=0: stall=1 combinationally; next edge goes to LOAD_WAIT, latches rd_in/we_in/sel, wb_valid=0.
REQ-026 LOAD_WAIT: stall=1 while mem_rdy=0; wb_valid=0; src_req/in_valid ignored.
REQ-027 LOAD_WAIT, mem_rdy=1: stall=0 that cycle; next edge captures src_data slot LOAD_IDX with latched rd/we, wb_valid=1, returns to IDLE.
REQ-028 in_valid=0 in IDLE: next edge wb_valid=0, wb_we=0; wb_data, wb_rd, wb_sel hold.
REQ-029 Multiple src_req bits set: priority of REQ-021 applies; no error raised.
REQ-030 Load accepted back-to-back with a non-load: no bubble unless the load waits.

Reset
REQ-031 reset=1 at an edge: state=IDLE, wb_valid=0, wb_we=0, wb_data=0, wb_rd=0, wb_sel=DEFAULT_IDX.
REQ-032 stall=0 while reset=1; a pending LOAD_WAIT is abandoned and never written back.
REQ-033 reset overrides mem_rdy and in_valid in the same cycle.

Structure
REQ-034 Shared package holds the source-index constants (SRC_PC=0, SRC_CALL=1, SRC_ALU=2, SRC_LOAD=3) and the state enumeration.
REQ-035 One sub-module, wb_prio_encoder (NSRC-bit request to SELW index plus any-valid flag); everything else flat.

Verification
REQ-036 Reset asserted mid LOAD_WAIT -> next cycle wb_valid=0, stall=0, wb_sel=0; later mem_rdy=1 produces no write-back.
REQ-037 src_req=4'b0100, src_data slot2=32'h0000_1234, rd_in=5, we_in=1 -> one cycle later wb_data=32'h1234, wb_rd=5, wb_we=1, wb_sel=2.
REQ-038 src_req=4'b0110 -> wb_sel=1 (priority); src_req=0 -> wb_sel=0 and slot0 data.
REQ-039 Load with mem_rdy low 3 cycles then slot3=32'hDEAD_BEEF -> stall high 3 cycles, wb_valid 0 for those cycles, then wb_data=32'hDEADBEEF with latched rd.
REQ-040 Load with mem_rdy=1 immediately followed by ALU op -> consecutive wb_valid=1 cycles, wb_sel 3 then 2, stall never high.
REQ-041 Parameter sweep NSRC=2 and NSRC=8, WIDTH=64 -> priority and capture of REQ-037/038 hold at every index.
